// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the SRAM bank read sequencer: default bank
// address width, command length width and the sequencer FSM state type.
package mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_LEN_W  = MEM_ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } mem_state_e;

    // Length field needs one extra bit so a full bank (2^addr_w words)
    // can be requested.
    function automatic int mem_len_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/mem_skew_line.sv
// mem_skew_line
// SYS_ROW-stage delay line for {en, addr}. Stage i carries the bank-0
// issue stream delayed by i+1 advancing cycles. While hold is high every
// stage keeps its contents, addresses stay on the outputs and all output
// enables are forced low for the following cycle.
//
// Ports
//   clk, rstn    clock, async active-low reset
//   hold         freeze the line and blank the enables
//   in_en        bank-0 issue strobe for the next stage-0 load
//   in_addr      bank-0 issue address
//   out_en       per-stage registered read strobe
//   out_addr     per-stage registered read address
module mem_skew_line
    import mem_pkg::*;
#(
    parameter int SYS_ROW = 16,
    parameter int ADDR_W  = MEM_ADDR_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               hold,
    input  logic               in_en,
    input  logic [ADDR_W-1:0]  in_addr,
    output logic [SYS_ROW-1:0] out_en,
    output logic [ADDR_W-1:0]  out_addr [0:SYS_ROW-1]
);

    logic [SYS_ROW-1:0] en_q, en_d;
    logic [SYS_ROW-1:0] en_out_q, en_out_d;
    logic [ADDR_W-1:0]  addr_q [0:SYS_ROW-1];
    logic [ADDR_W-1:0]  addr_d [0:SYS_ROW-1];

    // en_q remembers which stages hold a live read across a hold; the
    // visible strobe en_out_q is blanked separately so nothing is lost.
    always_comb begin
        en_d     = en_q;
        addr_d   = addr_q;
        en_out_d = '0;
        if (!hold) begin
            en_d[0]   = in_en;
            addr_d[0] = in_addr;
            for (int i = 1; i < SYS_ROW; i++) begin
                en_d[i]   = en_q[i-1];
                addr_d[i] = addr_q[i-1];
            end
            en_out_d = en_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q     <= '0;
            en_out_q <= '0;
            for (int i = 0; i < SYS_ROW; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            en_q     <= en_d;
            en_out_q <= en_out_d;
            for (int i = 0; i < SYS_ROW; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

    assign out_en   = en_out_q;
    assign out_addr = addr_q;

endmodule

// File: rtl/mem_rd_seq.sv
// mem_rd_seq
// Read sequencer for the per-row SRAM bank array. Takes a tile command
// (base, len) and issues len consecutive reads per bank with a one-cycle
// diagonal skew between neighbouring banks, produces per-row data-valid
// strobes aligned to SRAM read data, honours downstream stall and pulses
// done with the last row's final valid beat.
//
// Ports
//   clk, rstn        clock, async active-low reset
//   cmd_valid/ready  tile command handshake
//   cmd_base         first word address of the tile
//   cmd_len          vectors per bank, 0..2^ADDR_W
//   stall            downstream backpressure
//   rd_en, rd_addr   per-bank SRAM read port
//   row_valid        rd_data[i] valid this cycle
//   busy             tile in progress
//   done             one-cycle tile-complete pulse
//
// state | meaning
// IDLE  | ready for a command; len=0 commands complete here
// ISSUE | bank 0 stepping through base..base+len-1
// DRAIN | skew line and read latency emptying; ends with done
module mem_rd_seq
    import mem_pkg::*;
#(
    parameter int SYS_ROW = 16,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_W-1:0]  cmd_base,
    input  logic [ADDR_W:0]    cmd_len,
    input  logic               stall,
    output logic [SYS_ROW-1:0] rd_en,
    output logic [ADDR_W-1:0]  rd_addr [0:SYS_ROW-1],
    output logic [SYS_ROW-1:0] row_valid,
    output logic               busy,
    output logic               done
);

    localparam int LEN_W    = mem_len_w(ADDR_W);
    localparam int DRN_INIT = SYS_ROW - 1 + RD_LAT;
    localparam int DRN_W    = $clog2(DRN_INIT + 1);

    mem_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
    logic [LEN_W-1:0]    remain_q, remain_d;
    logic [DRN_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                issue_en;
    logic [ADDR_W-1:0]   issue_addr;
    logic                drain_step;
    logic [SYS_ROW-1:0]  vld_q [0:RD_LAT-1];
    logic [SYS_ROW-1:0]  vld_d [0:RD_LAT-1];

    // The first SYS_ROW-1 drain steps move the last vector through the
    // skew line and only advance on non-stalled cycles. The final RD_LAT
    // steps track the free-running valid pipe, so they ignore stall and
    // done stays aligned with the last row_valid beat.
    assign drain_step = !stall || (drain_cnt_q <= DRN_W'(RD_LAT));

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        remain_d    = remain_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        issue_en    = 1'b0;
        issue_addr  = next_addr_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else if (stall) begin
                        // Skew line is frozen this cycle; start from base in ISSUE.
                        next_addr_d = cmd_base;
                        remain_d    = cmd_len;
                        state_d     = ISSUE;
                    end else begin
                        issue_en    = 1'b1;
                        issue_addr  = cmd_base;
                        next_addr_d = cmd_base + ADDR_W'(1);
                        remain_d    = cmd_len - LEN_W'(1);
                        if (cmd_len == LEN_W'(1)) begin
                            state_d     = DRAIN;
                            drain_cnt_d = DRN_W'(DRN_INIT);
                        end else begin
                            state_d = ISSUE;
                        end
                    end
                end
            end
            ISSUE: begin
                if (!stall) begin
                    issue_en    = 1'b1;
                    next_addr_d = next_addr_q + ADDR_W'(1);
                    remain_d    = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRN_W'(DRN_INIT);
                    end
                end
            end
            DRAIN: begin
                if (done_q) begin
                    state_d = IDLE;
                end else if (drain_step) begin
                    drain_cnt_d = drain_cnt_q - DRN_W'(1);
                    if (drain_cnt_q == DRN_W'(1)) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d != IDLE);
        cmd_ready_d = (state_d == IDLE) && !done_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            remain_q    <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            remain_q    <= remain_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    mem_skew_line #(
        .SYS_ROW (SYS_ROW),
        .ADDR_W  (ADDR_W)
    ) u_skew (
        .clk      (clk),
        .rstn     (rstn),
        .hold     (stall),
        .in_en    (issue_en),
        .in_addr  (issue_addr),
        .out_en   (rd_en),
        .out_addr (rd_addr)
    );

    // Valid pipe mirrors SRAM read latency and runs regardless of stall.
    always_comb begin
        vld_d[0] = rd_en;
        for (int k = 1; k < RD_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < RD_LAT; k++) begin
                vld_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < RD_LAT; k++) begin
                vld_q[k] <= vld_d[k];
            end
        end
    end

    assign row_valid = vld_q[RD_LAT-1];
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_mem_rd_seq.sv
// tb_mem_rd_seq
// Directed bench for mem_rd_seq: single tiles (plain, address wrap, len=0,
// full 256, stalls in ISSUE and DRAIN), back-to-back commands and an
// asynchronous reset in the middle of DRAIN. Inputs change and outputs are
// sampled on the falling edge.
module tb_mem_rd_seq;

    localparam int SYS_ROW = 16;
    localparam int ADDR_W  = 8;
    localparam int RD_LAT  = 1;

    logic               clk;
    logic               rstn;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [ADDR_W-1:0]  cmd_base;
    logic [ADDR_W:0]    cmd_len;
    logic               stall;
    logic [SYS_ROW-1:0] rd_en;
    logic [ADDR_W-1:0]  rd_addr [0:SYS_ROW-1];
    logic [SYS_ROW-1:0] row_valid;
    logic               busy;
    logic               done;

    int checks;
    int errors;

    mem_rd_seq #(
        .SYS_ROW (SYS_ROW),
        .ADDR_W  (ADDR_W),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .stall     (stall),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .row_valid (row_valid),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        logic [ADDR_W-1:0] aor;
        aor = '0;
        for (int i = 0; i < SYS_ROW; i++) aor |= rd_addr[i];
        chk({tag, "_rdy"},   32'(cmd_ready), 32'd1);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_rden"},  32'(rd_en),     32'd0);
        chk({tag, "_rv"},    32'(row_valid), 32'd0);
        chk({tag, "_addr"},  32'(aor),       32'd0);
    endtask

    // One tile accepted in cycle 0; stall held for st_n cycles from cycle st_at.
    task automatic run_tile(input string tag, input logic [ADDR_W-1:0] base,
                            input int len, input int st_at, input int st_n);
        int cnt [SYS_ROW];
        int first [SYS_ROW];
        int last [SYS_ROW];
        int exp_done;
        int addr_err;
        int vld_err;
        int cnt_err;
        int skew_err;
        int done_cnt;
        int done_at;
        logic [SYS_ROW-1:0] prev_en;
        logic [ADDR_W-1:0]  ea;

        exp_done = (len == 0) ? 1 : len + SYS_ROW - 1 + RD_LAT + st_n;
        addr_err = 0; vld_err = 0; cnt_err = 0; skew_err = 0;
        done_cnt = 0; done_at = -1;
        for (int i = 0; i < SYS_ROW; i++) begin
            cnt[i] = 0; first[i] = -1; last[i] = -1;
        end

        @(negedge clk);
        chk({tag, "_rdy0"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rv0"},  32'(row_valid), 32'd0);
        prev_en   = rd_en;
        cmd_valid = 1'b1;
        cmd_base  = base;
        cmd_len   = 9'(len);
        stall     = (st_n > 0) && (st_at == 0);

        for (int k = 1; k <= exp_done + 1; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (k == 1) chk({tag, "_busy1"}, 32'(busy), (len > 0) ? 32'd1 : 32'd0);
            for (int i = 0; i < SYS_ROW; i++) begin
                if (rd_en[i]) begin
                    if (first[i] < 0) first[i] = k;
                    last[i] = k;
                    ea = base + ADDR_W'(cnt[i]);
                    if (rd_addr[i] !== ea) addr_err++;
                    cnt[i]++;
                end
            end
            if (row_valid !== prev_en) vld_err++;
            prev_en = rd_en;
            if (st_n > 0 && k > st_at && k <= st_at + st_n)
                chk($sformatf("%s_stall_rden_c%0d", tag, k), 32'(rd_en), 32'd0);
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k == exp_done)     chk({tag, "_rdy_at_done"}, 32'(cmd_ready), 32'd0);
            if (k == exp_done + 1) begin
                chk({tag, "_rdy_after"},  32'(cmd_ready), 32'd1);
                chk({tag, "_busy_after"}, 32'(busy),      32'd0);
            end
            stall = (k >= st_at) && (k < st_at + st_n);
        end
        stall = 1'b0;

        for (int i = 0; i < SYS_ROW; i++) begin
            if (cnt[i] != len) cnt_err++;
            if (first[i] != 1 + i || last[i] != len + i) skew_err++;
        end
        chk({tag, "_done_at"},  32'(done_at),  32'(exp_done));
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_cnt0"},     32'(cnt[0]),   32'(len));
        chk({tag, "_cnt_err"},  32'(cnt_err),  32'd0);
        chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
        chk({tag, "_vld_err"},  32'(vld_err),  32'd0);
        if (st_n == 0 && len > 0) begin
            chk({tag, "_first0"},   32'(first[0]),         32'd1);
            chk({tag, "_last15"},   32'(last[SYS_ROW-1]),  32'(len + SYS_ROW - 1));
            chk({tag, "_skew_err"}, 32'(skew_err),         32'd0);
        end
    endtask

    task automatic run_back_to_back();
        int a_beats;
        int b_beats;
        int b_first;
        int b_addr_err;
        int n_done;
        int done_k [2];
        logic [ADDR_W-1:0] ea;

        a_beats = 0; b_beats = 0; b_first = -1; b_addr_err = 0;
        n_done = 0; done_k[0] = -1; done_k[1] = -1;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_base  = 8'h40;
        cmd_len   = 9'd2;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_base = 8'h80;
                cmd_len  = 9'd3;
            end
            if (rd_en[0]) begin
                if (k <= 19) begin
                    a_beats++;
                end else begin
                    if (b_first < 0) b_first = k;
                    ea = 8'h80 + ADDR_W'(b_beats);
                    if (rd_addr[0] !== ea) b_addr_err++;
                    b_beats++;
                end
            end
            if (done) begin
                if (n_done < 2) done_k[n_done] = k;
                n_done++;
            end
            if (k == 18) chk("b2b_rdy_at_done", 32'(cmd_ready), 32'd0);
            if (k == 19) chk("b2b_rdy_after",   32'(cmd_ready), 32'd1);
            if (k == 20) cmd_valid = 1'b0;
        end
        chk("b2b_a_beats",  32'(a_beats),    32'd2);
        chk("b2b_b_first",  32'(b_first),    32'd20);
        chk("b2b_b_beats",  32'(b_beats),    32'd3);
        chk("b2b_b_addr",   32'(b_addr_err), 32'd0);
        chk("b2b_n_done",   32'(n_done),     32'd2);
        chk("b2b_done_a",   32'(done_k[0]),  32'd18);
        chk("b2b_done_b",   32'(done_k[1]),  32'd38);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        stall     = 1'b0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rstn = 1'b1;
        @(negedge clk);

        run_tile("t_basic", 8'h10, 4,   0,  0);
        run_tile("t_wrap",  8'hFE, 4,   0,  0);
        run_tile("t_len0",  8'h55, 0,   0,  0);
        run_tile("t_full",  8'h00, 256, 0,  0);
        run_tile("t_stl_i", 8'h60, 8,   3,  3);
        run_tile("t_stl_d", 8'h70, 2,   10, 2);
        run_tile("t_stl_0", 8'hA0, 3,   0,  1);

        run_back_to_back();

        // Reset in the middle of DRAIN, then a clean follow-up tile.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_base  = 8'h20;
        cmd_len   = 9'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        chk("rst_pre_rden", 32'(rd_en != '0), 32'd1);
        #2 rstn = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        run_tile("t_post_rst", 8'h33, 2, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
